seg7_scanner: RTL and testbench

//  Time-multiplexed 7-segment display driver. Sits downstream of the register file.

---
 rtl/seg7_scanner.sv | 125 ++++++++++++
 tb/tb_seg7_scanner.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scanner.sv
`timescale 1ns/1ps
// Time-multiplexed 8-digit common-anode 7-segment driver: per-frame snapshot,
// leading-zero blanking, 16-level PWM dimming, registered active-low outputs.
module seg7_scanner #(
    parameter int unsigned PRESCALE = 100000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [27:0] disp_data,
    input  logic [6:0]  dp_mask,
    input  logic        blank_lz,
    input  logic        freeze,
    input  logic [3:0]  brightness,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [7:0]  an_n
);

    localparam int unsigned CW   = $clog2(PRESCALE);
    localparam int unsigned TW   = $clog2(PRESCALE + 1);
    localparam int unsigned STEP = PRESCALE / 16;
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_slot;
    logic [27:0]   r_shd_data;
    logic [6:0]    r_shd_dp;
    logic [3:0]    r_shd_brt;

    logic          w_cnt_wrap;
    logic          w_snap;
    logic [TW-1:0] w_thr;
    logic [27:0]   w_upper;
    logic [7:0]    w_dp_ext;
    logic          w_lz;
    logic          w_on;
    logic [7:0]    w_an_nxt;
    logic [6:0]    w_seg_nxt;
    logic          w_dp_nxt;

    function automatic logic [6:0] hex_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign w_cnt_wrap = (r_cnt == CNT_MAX);
    assign w_snap     = w_cnt_wrap && (r_slot == 3'd7);

    // Slot/cycle counters; slot 7 is the dark slot of each frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_slot <= '0;
        end else if (w_cnt_wrap) begin
            r_cnt  <= '0;
            r_slot <= r_slot + 3'd1;
        end else begin
            r_cnt  <= r_cnt + CW'(1);
        end
    end

    // Frame snapshot at the last cycle of the dark slot keeps each frame tear-free.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shd_data <= '0;
            r_shd_dp   <= '0;
            r_shd_brt  <= '0;
        end else if (w_snap) begin
            r_shd_brt <= brightness;
            if (!freeze) begin
                r_shd_data <= disp_data;
                r_shd_dp   <= dp_mask;
            end
        end
    end

    // phase <= brt  is equivalent to  cnt < (brt+1)*STEP, avoiding a divider.
    assign w_thr    = TW'((32'(r_shd_brt) + 32'd1) * STEP);
    assign w_upper  = r_shd_data >> {r_slot, 2'b00};
    assign w_dp_ext = {1'b0, r_shd_dp};
    assign w_lz     = blank_lz && (r_slot != 3'd0) && (w_upper == 28'd0);
    assign w_on     = (r_slot != 3'd7) && (r_cnt != '0) && (TW'(r_cnt) < w_thr) && !w_lz;

    always_comb begin
        w_an_nxt  = 8'hFF;
        w_seg_nxt = 7'h7F;
        w_dp_nxt  = 1'b1;
        if (w_on) begin
            w_an_nxt  = ~(8'd1 << r_slot);
            w_seg_nxt = hex_seg(w_upper[3:0]);
            w_dp_nxt  = ~w_dp_ext[r_slot];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            an_n  <= 8'hFF;
            seg_n <= 7'h7F;
            dp_n  <= 1'b1;
        end else begin
            an_n  <= w_an_nxt;
            seg_n <= w_seg_nxt;
            dp_n  <= w_dp_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scanner.sv
`timescale 1ns/1ps
// Bench for seg7_scanner at PRESCALE=32: randomized stimulus against a frame-level
// model (position from cycle index, snapshot of inputs at each frame end).
module tb_seg7_scanner;

    localparam int P     = 32;
    localparam int FRAME = 8 * P;
    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clock = 1'b0;
    logic        reset_n;
    logic [27:0] disp_data;
    logic [6:0]  dp_mask;
    logic        blank_lz;
    logic        freeze;
    logic [3:0]  brightness;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [7:0]  an_n;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int          m_pos;
    logic [27:0] m_data;
    logic [6:0]  m_dp;
    logic [3:0]  m_brt;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    int          e_slot, e_cnt;

    // per-frame observations
    int         f_lit [8];
    logic [6:0] f_seg [8];
    int         f_mism, f_multi, f_dpbad, f_dplow, f_cmin, f_cmax;

    seg7_scanner #(.PRESCALE(P)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .disp_data  (disp_data),
        .dp_mask    (dp_mask),
        .blank_lz   (blank_lz),
        .freeze     (freeze),
        .brightness (brightness),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_pos  = 0;
        m_data = '0;
        m_dp   = '0;
        m_brt  = '0;
    endtask

    // One clock: expected output for the position scanned at this edge, then frame snapshot.
    task automatic tick();
        int q, s, c;
        logic [27:0] up;
        @(posedge clock);
        q = m_pos;
        s = (q / P) % 8;
        c = q % P;
        e_slot = s;
        e_cnt  = c;
        up = m_data >> (4 * s);
        e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
        if (s < 7 && c != 0 && (c / (P / 16)) <= int'(m_brt) && !(blank_lz && s != 0 && up == 28'd0)) begin
            e_an  = ~(8'd1 << s);
            e_seg = HEX[up[3:0]];
            e_dp  = ~m_dp[s];
        end
        if (q % FRAME == FRAME - 1) begin
            m_brt = brightness;
            if (!freeze) begin
                m_data = disp_data;
                m_dp   = dp_mask;
            end
        end
        m_pos++;
        #1;
    endtask

    task automatic align();
        do tick(); while (m_pos % FRAME != 0);
    endtask

    // Runs one aligned frame, collecting observations; optional disp_data change mid-frame.
    task automatic run_frame(input int chg_at, input logic [27:0] chg_data);
        for (int k = 0; k < 8; k++) begin f_lit[k] = 0; f_seg[k] = 7'h7F; end
        f_mism = 0; f_multi = 0; f_dpbad = 0; f_dplow = 0; f_cmin = P; f_cmax = -1;
        for (int i = 0; i < FRAME; i++) begin
            if (i == chg_at) disp_data = chg_data;
            tick();
            if ({an_n, seg_n, dp_n} !== {e_an, e_seg, e_dp}) f_mism++;
            if ($countones(~an_n) > 1) f_multi++;
            if ((dp_n == 1'b0) != (an_n[2] == 1'b0)) f_dpbad++;
            if (dp_n == 1'b0) f_dplow++;
            if (an_n == ~(8'd1 << e_slot)) begin
                f_lit[e_slot]++;
                f_seg[e_slot] = seg_n;
                if (e_cnt < f_cmin) f_cmin = e_cnt;
                if (e_cnt > f_cmax) f_cmax = e_cnt;
            end
        end
    endtask

    task automatic test_reset();
        int others;
        disp_data = 28'h1234567; dp_mask = 7'h7F; blank_lz = 1'b1; freeze = 1'b0; brightness = 4'hF;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if ({an_n, seg_n, dp_n} !== {8'hFF, 7'h7F, 1'b1}) begin
            n_errors++; $display("FAIL reset_idle got an=%h seg=%h dp=%b want FF/7F/1", an_n, seg_n, dp_n);
        end
        @(negedge clock); reset_n = 1'b1; model_reset();
        run_frame(-1, 28'h0);
        others = 0;
        for (int k = 1; k < 8; k++) others += f_lit[k];
        n_checks++;
        if (f_mism != 0) begin n_errors++; $display("FAIL reset_frame0_model got %0d bad cycles want 0", f_mism); end
        n_checks++;
        if (f_lit[0] != 1 || f_seg[0] !== 7'h40) begin
            n_errors++; $display("FAIL reset_frame0_digit0 got lit=%0d seg=%h want 1/40", f_lit[0], f_seg[0]);
        end
        n_checks++;
        if (others != 0) begin n_errors++; $display("FAIL reset_frame0_others got %0d lit want 0", others); end
        repeat (40) tick();
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({an_n, seg_n, dp_n} !== {8'hFF, 7'h7F, 1'b1}) begin
            n_errors++; $display("FAIL reset_mid got an=%h seg=%h dp=%b want FF/7F/1", an_n, seg_n, dp_n);
        end
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if ({an_n, seg_n, dp_n} !== {8'hFF, 7'h7F, 1'b1}) begin
            n_errors++; $display("FAIL reset_hold got an=%h seg=%h dp=%b want FF/7F/1", an_n, seg_n, dp_n);
        end
        @(negedge clock); reset_n = 1'b1; model_reset();
    endtask

    task automatic test_full_scan();
        disp_data = 28'h6543210; dp_mask = 7'h00; blank_lz = 1'b0; brightness = 4'hF;
        align();
        run_frame(-1, 28'h0);
        n_checks++;
        if (f_mism != 0) begin n_errors++; $display("FAIL scan_model got %0d bad cycles want 0", f_mism); end
        for (int k = 0; k < 7; k++) begin
            n_checks++;
            if (f_lit[k] != 31 || f_seg[k] !== HEX[k]) begin
                n_errors++; $display("FAIL scan_digit%0d got lit=%0d seg=%h want 31/%h", k, f_lit[k], f_seg[k], HEX[k]);
            end
        end
        n_checks++;
        if (f_lit[7] != 0) begin n_errors++; $display("FAIL scan_slot7 got %0d lit want 0", f_lit[7]); end
    endtask

    task automatic test_lz_blank();
        int others;
        disp_data = 28'h00000A0; blank_lz = 1'b1; brightness = 4'hF;
        align();
        run_frame(-1, 28'h0);
        others = 0;
        for (int k = 2; k < 8; k++) others += f_lit[k];
        n_checks++;
        if (f_mism != 0) begin n_errors++; $display("FAIL lz_model got %0d bad cycles want 0", f_mism); end
        n_checks++;
        if (f_lit[0] != 31 || f_seg[0] !== 7'h40 || f_lit[1] != 31 || f_seg[1] !== 7'h08) begin
            n_errors++;
            $display("FAIL lz_low_digits got %0d/%h %0d/%h want 31/40 31/08", f_lit[0], f_seg[0], f_lit[1], f_seg[1]);
        end
        n_checks++;
        if (others != 0) begin n_errors++; $display("FAIL lz_blanked got %0d lit want 0", others); end
        disp_data = 28'h0;
        align();
        run_frame(-1, 28'h0);
        others = 0;
        for (int k = 1; k < 8; k++) others += f_lit[k];
        n_checks++;
        if (f_lit[0] != 31 || f_seg[0] !== 7'h40 || others != 0) begin
            n_errors++; $display("FAIL lz_zero got d0=%0d/%h others=%0d want 31/40 0", f_lit[0], f_seg[0], others);
        end
    endtask

    task automatic test_pwm();
        int lvl [2] = '{3, 0};
        int want [2] = '{7, 1};
        blank_lz = 1'b0;
        for (int j = 0; j < 2; j++) begin
            disp_data  = 28'($urandom);
            brightness = 4'(lvl[j]);
            align();
            run_frame(-1, 28'h0);
            n_checks++;
            if (f_mism != 0) begin n_errors++; $display("FAIL pwm%0d_model got %0d bad cycles want 0", lvl[j], f_mism); end
            for (int k = 0; k < 7; k++) begin
                n_checks++;
                if (f_lit[k] != want[j]) begin
                    n_errors++; $display("FAIL pwm%0d_digit%0d got %0d lit want %0d", lvl[j], k, f_lit[k], want[j]);
                end
            end
            n_checks++;
            if (f_cmin != 1 || f_cmax != want[j]) begin
                n_errors++; $display("FAIL pwm%0d_window got cnt %0d..%0d want 1..%0d", lvl[j], f_cmin, f_cmax, want[j]);
            end
        end
    endtask

    task automatic test_freeze();
        logic [27:0] a, b, c;
        a = 28'($urandom); b = 28'($urandom); c = 28'($urandom);
        blank_lz = 1'b0; brightness = 4'hF; freeze = 1'b0;
        disp_data = a;
        align();
        run_frame(100, b);
        n_checks++;
        if (f_mism != 0) begin n_errors++; $display("FAIL tear_model got %0d bad cycles want 0", f_mism); end
        for (int k = 0; k < 7; k++) begin
            n_checks++;
            if (f_seg[k] !== HEX[a[4*k +: 4]]) begin
                n_errors++; $display("FAIL tear_digit%0d got %h want %h", k, f_seg[k], HEX[a[4*k +: 4]]);
            end
        end
        run_frame(-1, 28'h0);
        freeze = 1'b1; brightness = 4'd3; disp_data = c;
        run_frame(-1, 28'h0);
        run_frame(-1, 28'h0);
        n_checks++;
        if (f_mism != 0) begin n_errors++; $display("FAIL freeze_model got %0d bad cycles want 0", f_mism); end
        for (int k = 0; k < 7; k++) begin
            n_checks++;
            if (f_seg[k] !== HEX[b[4*k +: 4]] || f_lit[k] != 7) begin
                n_errors++;
                $display("FAIL freeze_digit%0d got %h/%0d want %h/7", k, f_seg[k], f_lit[k], HEX[b[4*k +: 4]]);
            end
        end
        freeze = 1'b0;
        run_frame(-1, 28'h0);
        run_frame(-1, 28'h0);
        n_checks++;
        if (f_seg[6] !== HEX[c[27:24]] || f_mism != 0) begin
            n_errors++; $display("FAIL unfreeze got seg6=%h mism=%0d want %h/0", f_seg[6], f_mism, HEX[c[27:24]]);
        end
    endtask

    task automatic test_dp();
        disp_data = 28'($urandom) | 28'h8000000; dp_mask = 7'b0000100; blank_lz = 1'b0; brightness = 4'hF;
        align();
        run_frame(-1, 28'h0);
        n_checks++;
        if (f_dpbad != 0 || f_dplow != 31) begin
            n_errors++; $display("FAIL dp_digit2 got bad=%0d low=%0d want 0/31", f_dpbad, f_dplow);
        end
        n_checks++;
        if (f_multi != 0) begin n_errors++; $display("FAIL dp_onehot got %0d multi-anode cycles want 0", f_multi); end
        n_checks++;
        if (f_mism != 0) begin n_errors++; $display("FAIL dp_model got %0d bad cycles want 0", f_mism); end
    endtask

    task automatic test_random();
        for (int j = 0; j < 6; j++) begin
            brightness = 4'($urandom);
            blank_lz   = 1'($urandom);
            freeze     = ($urandom_range(0, 3) == 0);
            dp_mask    = 7'($urandom);
            disp_data  = ($urandom_range(0, 1) == 0) ? 28'($urandom) >> (4 * $urandom_range(0, 6)) : 28'($urandom);
            run_frame(int'($urandom_range(0, FRAME - 1)), 28'($urandom) >> (4 * $urandom_range(0, 6)));
            n_checks++;
            if (f_mism != 0 || f_multi != 0) begin
                n_errors++; $display("FAIL random%0d got mism=%0d multi=%0d want 0/0", j, f_mism, f_multi);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_scan();
        test_lz_blank();
        test_pwm();
        test_freeze();
        test_dp();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
